// File: rtl/fm_mem_arbiter.sv
// rtl/fm_mem_arbiter.sv - feature-map RAM arbiter, round-robin read and write ports for conv/pool clients
// Optional zero-fill sweep (clear / clear_busy) enabled by FM_ARB_CLEAR_EN.
module fm_mem_arbiter #(
  parameter int COORD_BITS       = 8,
  parameter int CHANNELS         = 4,
  parameter int BITS_PER_CHANNEL = 9,
  parameter int IMG_WIDTH        = 32,
  parameter int IMG_HEIGHT       = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [1:0][2*COORD_BITS-1:0]               coord_get,
  input  logic [1:0]                                 read_req,
  output logic [1:0]                                 read_ready,
  output logic [CHANNELS*BITS_PER_CHANNEL-1:0]       data_out,
  input  logic [1:0][2*COORD_BITS-1:0]               coord_wtr,
  input  logic [1:0][CHANNELS*BITS_PER_CHANNEL-1:0]  data_in,
  input  logic [1:0]                                 write_req,
  output logic [1:0]                                 write_ready
`ifdef FM_ARB_CLEAR_EN
  ,
  input  logic                                       clear,
  output logic                                       clear_busy
`endif
);
  localparam int DW    = CHANNELS * BITS_PER_CHANNEL;
  localparam int DEPTH = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DONE} r_state_t;
  typedef enum logic       {W_IDLE, W_ACK} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [DW-1:0] mem [DEPTH];

  logic          r_grant_en, r_sel, r_gnt, r_last, r_valid;
  logic [AW-1:0] r_addr;
  logic          w_grant_en, w_sel, w_gnt, w_last, w_valid;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          grant_hold;
  logic          w_commit;

  function automatic logic [AW-1:0] calc_addr(input logic [2*COORD_BITS-1:0] c);
    return AW'(c[2*COORD_BITS-1:COORD_BITS]) * AW'(IMG_WIDTH) + AW'(c[COORD_BITS-1:0]);
  endfunction

  function automatic logic in_range(input logic [2*COORD_BITS-1:0] c);
    return (32'(c[COORD_BITS-1:0]) < 32'(IMG_WIDTH)) &&
           (32'(c[2*COORD_BITS-1:COORD_BITS]) < 32'(IMG_HEIGHT));
  endfunction

  // Round-robin: on a tie the client not granted last time wins.
  function automatic logic pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

  assign r_sel    = pick(read_req, r_last);
  assign w_sel    = pick(write_req, w_last);
  assign w_commit = (w_state == W_ACK) && w_valid;

`ifdef FM_ARB_CLEAR_EN
  logic [AW-1:0] clr_cnt;
  logic          clr_start;
  assign clr_start  = clear && !clear_busy && (r_state == R_IDLE) && (w_state == W_IDLE);
  assign grant_hold = clear_busy || clr_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_busy <= 1'b0;
      clr_cnt    <= '0;
    end else if (clr_start) begin
      clear_busy <= 1'b1;
      clr_cnt    <= '0;
    end else if (clear_busy) begin
      if (clr_cnt == AW'(DEPTH - 1)) clear_busy <= 1'b0;
      clr_cnt <= clr_cnt + 1'b1;
    end
  end
`else
  assign grant_hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  always_comb begin
    r_next     = r_state;
    r_grant_en = 1'b0;
    read_ready = '0;
    case (r_state)
      R_IDLE: if (|read_req && !grant_hold) begin
        r_grant_en = 1'b1;
        r_next     = R_WAIT;
      end
      R_WAIT: r_next = R_DONE;
      R_DONE: begin
        read_ready[r_gnt] = 1'b1;
        r_next            = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_next      = w_state;
    w_grant_en  = 1'b0;
    write_ready = '0;
    case (w_state)
      W_IDLE: if (|write_req && !grant_hold) begin
        w_grant_en = 1'b1;
        w_next     = W_ACK;
      end
      W_ACK: begin
        write_ready[w_gnt] = 1'b1;
        w_next             = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_addr   <= '0;
      r_valid  <= 1'b0;
      data_out <= '0;
    end else begin
      if (r_grant_en) begin
        r_gnt   <= r_sel;
        r_last  <= r_sel;
        r_addr  <= calc_addr(coord_get[r_sel]);
        r_valid <= in_range(coord_get[r_sel]);
      end
      // Write-first: a commit to the address being read this cycle is forwarded.
      if (r_state == R_WAIT) begin
        if (!r_valid)                            data_out <= '0;
        else if (w_commit && (w_addr == r_addr)) data_out <= w_data;
        else                                     data_out <= mem[r_addr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_gnt   <= 1'b0;
      w_last  <= 1'b1;
      w_addr  <= '0;
      w_valid <= 1'b0;
      w_data  <= '0;
    end else if (w_grant_en) begin
      w_gnt   <= w_sel;
      w_last  <= w_sel;
      w_addr  <= calc_addr(coord_wtr[w_sel]);
      w_valid <= in_range(coord_wtr[w_sel]);
      w_data  <= data_in[w_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) mem[w_addr] <= w_data;
`ifdef FM_ARB_CLEAR_EN
    if (clear_busy) mem[clr_cnt] <= '0;
`endif
  end

endmodule

// File: tb/tb_fm_mem_arbiter.sv
// tb/tb_fm_mem_arbiter.sv - self-checking bench for fm_mem_arbiter
// Vector table, corner sequences and a randomized phase against a coordinate-keyed memory model.
module tb_fm_mem_arbiter;
  localparam int DW = 36;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0][15:0]     coord_get;
  logic [1:0]           read_req;
  logic [1:0]           read_ready;
  logic [DW-1:0]        data_out;
  logic [1:0][15:0]     coord_wtr;
  logic [1:0][DW-1:0]   data_in;
  logic [1:0]           write_req;
  logic [1:0]           write_ready;
`ifdef FM_ARB_CLEAR_EN
  logic                 clear;
  logic                 clear_busy;
`endif

  fm_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .coord_get(coord_get), .read_req(read_req), .read_ready(read_ready), .data_out(data_out),
    .coord_wtr(coord_wtr), .data_in(data_in), .write_req(write_req), .write_ready(write_ready)
`ifdef FM_ARB_CLEAR_EN
    , .clear(clear), .clear_busy(clear_busy)
`endif
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  logic [DW-1:0] model [int];

  typedef struct {
    bit            rd;
    int            c;
    int            x;
    int            y;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1; lat counts negedges after issue (-1 on timeout).
  task automatic run_txn(input bit rd, input int c, input int x, input int y,
                         input logic [DW-1:0] d, output int lat, output logic [DW-1:0] q);
    lat = -1;
    q   = '0;
    if (rd) begin
      coord_get[c] = {8'(y), 8'(x)};
      read_req[c]  = 1'b1;
    end else begin
      coord_wtr[c] = {8'(y), 8'(x)};
      data_in[c]   = d;
      write_req[c] = 1'b1;
    end
    for (int k = 0; k < 8 && lat < 0; k++) begin
      @(negedge clk);
      if (rd ? read_ready[c] : write_ready[c]) begin
        lat = k;
        q   = data_out;
      end
      @(posedge clk); #1;
    end
    if (rd) read_req[c] = 1'b0;
    else    write_req[c] = 1'b0;
    if (!rd && x < 32 && y < 32) model[y*32 + x] = d;
  endtask

  initial begin
    int lat, wk, rk, n, t0, t1, ready_seen;
    int order [4];
    int when [4];
    logic [DW-1:0] q, d0, d1;

    rst = 1'b1;
    read_req = '0; write_req = '0;
    coord_get = '0; coord_wtr = '0; data_in = '0;
`ifdef FM_ARB_CLEAR_EN
    clear = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_read_ready", read_ready, 0);
    check("reset_write_ready", write_ready, 0);
    check("reset_data_out", data_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    tbl[0] = '{0, 0,  3,  5, 36'h123456789, 36'h0};
    tbl[1] = '{1, 1,  3,  5, 36'h0,         36'h123456789};
    tbl[2] = '{0, 1,  0,  1, 36'hFEDCBA987, 36'h0};
    tbl[3] = '{0, 0,  0,  0, 36'h0A5A5A5A5, 36'h0};
    tbl[4] = '{1, 0, 32,  0, 36'h0,         36'h0};
    tbl[5] = '{0, 0, 31, 31, 36'h800000001, 36'h0};
    tbl[6] = '{1, 1, 31, 31, 36'h0,         36'h800000001};
    tbl[7] = '{0, 1,  0, 32, 36'hDEADBEEF1, 36'h0};
    tbl[8] = '{1, 1,  0,  0, 36'h0,         36'h0A5A5A5A5};
    tbl[9] = '{1, 0,  0,  1, 36'h0,         36'hFEDCBA987};
    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].rd, tbl[i].c, tbl[i].x, tbl[i].y, tbl[i].d, lat, q);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].rd ? 2 : 1);
      if (tbl[i].rd) check($sformatf("vec%0d_data", i), q, tbl[i].exp);
    end

    // Both clients hold write_req; last write grant was client 1.
    coord_wtr[0] = {8'd10, 8'd10}; data_in[0] = 36'h00000AAAA;
    coord_wtr[1] = {8'd11, 8'd11}; data_in[1] = 36'h00000BBBB;
    write_req = 2'b11;
    n = 0;
    for (int k = 0; k < 12 && n < 4; k++) begin
      @(negedge clk);
      if (write_ready == 2'b11) check("wr_both_ready", write_ready, 2'b01);
      if (write_ready[0])      begin order[n] = 0; when[n] = k; n++; end
      else if (write_ready[1]) begin order[n] = 1; when[n] = k; n++; end
      @(posedge clk); #1;
    end
    write_req = '0;
    check("wr_rr_count", n, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr_rr_order%0d", i), order[i], i % 2);
      check($sformatf("wr_rr_time%0d", i), when[i], 2*i + 1);
    end
    model[10*32 + 10] = 36'h00000AAAA;
    model[11*32 + 11] = 36'h00000BBBB;
    run_txn(1, 1, 10, 10, '0, lat, q);
    check("wr_rr_readback0", q, 36'h00000AAAA);
    run_txn(1, 0, 11, 11, '0, lat, q);
    check("wr_rr_readback1", q, 36'h00000BBBB);

    // Write commit and read sampling of (7,7) land in the same cycle.
    run_txn(0, 1, 7, 7, 36'h555, lat, q);
    coord_wtr[0] = {8'd7, 8'd7}; data_in[0] = 36'hABC; write_req[0] = 1'b1;
    coord_get[1] = {8'd7, 8'd7}; read_req[1] = 1'b1;
    wk = -1; rk = -1;
    for (int k = 0; k < 8 && rk < 0; k++) begin
      @(negedge clk);
      if (write_ready[0] && wk < 0) wk = k;
      if (read_ready[1]) begin rk = k; q = data_out; end
      @(posedge clk); #1;
      if (wk >= 0) write_req[0] = 1'b0;
    end
    read_req[1] = 1'b0;
    write_req[0] = 1'b0;
    model[7*32 + 7] = 36'hABC;
    check("fwd_write_latency", wk, 1);
    check("fwd_read_latency", rk, 2);
    check("fwd_data", q, 36'hABC);

    // Reset while the read FSM is in R_WAIT.
    coord_get[0] = {8'd5, 8'd3}; read_req[0] = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_read_ready", read_ready, 0);
    check("rst_mid_write_ready", write_ready, 0);
    check("rst_mid_data_out", data_out, 0);
    read_req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ready_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (read_ready != 0) ready_seen++;
      @(posedge clk); #1;
    end
    check("rst_mid_no_ready", ready_seen, 0);

    // Simultaneous reads right after reset: client 0 first, client 1 three cycles later.
    coord_get[0] = {8'd5, 8'd3};   read_req[0] = 1'b1;
    coord_get[1] = {8'd31, 8'd31}; read_req[1] = 1'b1;
    t0 = -1; t1 = -1; d0 = '0; d1 = '0;
    for (int k = 0; k < 12 && t1 < 0; k++) begin
      @(negedge clk);
      if (read_ready[0]) begin t0 = k; d0 = data_out; end
      if (read_ready[1]) begin t1 = k; d1 = data_out; end
      @(posedge clk); #1;
      if (t0 >= 0) read_req[0] = 1'b0;
      if (t1 >= 0) read_req[1] = 1'b0;
    end
    read_req = '0;
    check("rd_tie_time0", t0, 2);
    check("rd_tie_time1", t1, 5);
    check("rd_tie_data0", d0, 36'h123456789);
    check("rd_tie_data1", d1, 36'h800000001);

    // Randomized single transactions against the coordinate model.
    for (int i = 0; i < 60; i++) begin
      int c, x, y, key;
      bit rd, oor;
      logic [DW-1:0] d, exp;
      c   = int'($urandom_range(1, 0));
      oor = ($urandom_range(3, 0) == 0);
      x   = int'($urandom_range(31, 0));
      y   = int'($urandom_range(31, 0));
      if (oor) begin
        if ($urandom_range(1, 0) == 1) x = int'($urandom_range(200, 32));
        else                           y = int'($urandom_range(200, 32));
      end
      key = y*32 + x;
      rd  = ($urandom_range(1, 0) == 1);
      if (rd && !oor && !model.exists(key)) rd = 1'b0;
      d   = {4'($urandom), $urandom};
      exp = (rd && !oor) ? model[key] : '0;
      run_txn(rd, c, x, y, d, lat, q);
      check($sformatf("rand%0d_latency", i), lat, rd ? 2 : 1);
      if (rd) check($sformatf("rand%0d_data(%0d,%0d)", i, x, y), q, exp);
    end

`ifdef FM_ARB_CLEAR_EN
    begin
      int busy_n, rd_k;
      bit early;
      run_txn(0, 0, 0, 0, 36'h111, lat, q);
      run_txn(0, 1, 31, 31, 36'h222, lat, q);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      busy_n = 0; rd_k = -1; early = 1'b0; q = 'x;
      for (int k = 0; k < 1200 && rd_k < 0; k++) begin
        @(negedge clk);
        if (clear_busy) busy_n++;
        if (read_ready[1]) begin
          rd_k = k;
          q = data_out;
          if (clear_busy) early = 1'b1;
        end
        @(posedge clk); #1;
        if (busy_n == 500 && !read_req[1]) begin
          coord_get[1] = {8'd31, 8'd31};
          read_req[1]  = 1'b1;
        end
        if (rd_k >= 0) read_req[1] = 1'b0;
      end
      read_req[1] = 1'b0;
      check("clear_busy_cycles", busy_n, 1024);
      check("clear_read_after_sweep", (rd_k > 0) && !early, 1);
      check("clear_read_data", q, 0);
      run_txn(1, 0, 0, 0, '0, lat, q);
      check("clear_origin_zero", q, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
